// File: rtl/btb_predictor_if.sv
// Fetch/decode/exec side-band bundle of the branch target buffer.
// master = pipeline side, slave = btb_predictor.
interface btb_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 3
);
  logic              f_hit;
  logic [IDX_W-1:0]  f_hit_idx;
  logic [ADDR_W-1:0] f_predict_addr;
  logic              f_predict_valid;
  logic [ADDR_W-1:0] f_pc;
  logic              d_alloc;
  logic [ADDR_W-1:0] d_pc;
  logic [ADDR_W-1:0] d_target;
  logic              x_update;
  logic [IDX_W-1:0]  x_idx;
  logic [ADDR_W-1:0] x_pc;
  logic              x_taken;
  logic [ADDR_W-1:0] x_target;

  modport master (
    output f_pc, d_alloc, d_pc, d_target, x_update, x_idx, x_pc, x_taken, x_target,
    input  f_hit, f_hit_idx, f_predict_addr, f_predict_valid
  );

  modport slave (
    input  f_pc, d_alloc, d_pc, d_target, x_update, x_idx, x_pc, x_taken, x_target,
    output f_hit, f_hit_idx, f_predict_addr, f_predict_valid
  );
endinterface

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating counters, unique-tag allocation and tag-checked training.
// Optional BTB_PERF_CNT_EN adds saturating hit/update/mispredict counters.
module btb_predictor #(
  parameter int         ADDR_W   = 32,
  parameter int         ENTRIES  = 8,
  parameter int         IDX_W    = 3,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0] perf_hits,
  output logic [31:0] perf_updates,
  output logic [31:0] perf_mispred,
`endif
  btb_predictor_if.slave bus
);

  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [ENTRIES-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               present;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               do_alloc;
  logic               upd_ok;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Lookup and allocation search both read pre-edge state only.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    present    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld_q[i] && tag_q[i] == bus.f_pc) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (vld_q[i] && tag_q[i] == bus.d_pc) present = 1'b1;
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    victim   = free_found ? free_idx : rr_q;
    do_alloc = bus.d_alloc && !present;
    // A training write aimed at the entry being reallocated is stale by definition.
    upd_ok   = bus.x_update && vld_q[bus.x_idx] && tag_q[bus.x_idx] == bus.x_pc &&
               !(do_alloc && victim == bus.x_idx);
  end

  assign bus.f_hit           = hit;
  assign bus.f_hit_idx       = hit_idx;
  assign bus.f_predict_addr  = hit ? tgt_q[hit_idx] : '0;
  assign bus.f_predict_valid = hit && cnt_q[hit_idx][1];

  always_comb begin
    tag_d = tag_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    rr_d  = rr_q;
    if (upd_ok) begin
      if (bus.x_taken) begin
        cnt_d[bus.x_idx] = sat_inc(cnt_q[bus.x_idx]);
        tgt_d[bus.x_idx] = bus.x_target;
      end else begin
        cnt_d[bus.x_idx] = sat_dec(cnt_q[bus.x_idx]);
      end
    end
    if (do_alloc) begin
      tag_d[victim] = bus.d_pc;
      tgt_d[victim] = bus.d_target;
      cnt_d[victim] = CNT_INIT;
      vld_d[victim] = 1'b1;
      if (!free_found) rr_d = rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    if (rst) begin
      vld_q <= '0;
      rr_q  <= '0;
      cnt_q <= '{default: CNT_INIT};
    end else begin
      vld_q <= vld_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_updates_q, perf_updates_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  always_comb begin
    perf_hits_d    = hit ? sat_inc32(perf_hits_q) : perf_hits_q;
    perf_updates_d = upd_ok ? sat_inc32(perf_updates_q) : perf_updates_q;
    perf_mispred_d = (upd_ok && (bus.x_taken != cnt_q[bus.x_idx][1])) ?
                     sat_inc32(perf_mispred_q) : perf_mispred_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_q    <= '0;
      perf_updates_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_hits_q    <= perf_hits_d;
      perf_updates_q <= perf_updates_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_hits    = perf_hits_q;
  assign perf_updates = perf_updates_q;
  assign perf_mispred = perf_mispred_q;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: literal expectations plus a per-cycle reference model.
module tb_btb_predictor;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 3;
  localparam int N      = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btb_predictor_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_hits, perf_updates, perf_mispred;
`endif

  btb_predictor #(.ADDR_W(ADDR_W), .ENTRIES(N), .IDX_W(IDX_W), .CNT_INIT(2'b10)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef BTB_PERF_CNT_EN
    .perf_hits    (perf_hits),
    .perf_updates (perf_updates),
    .perf_mispred (perf_mispred),
`endif
    .bus          (bus)
  );

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a table of (valid, pc, target, confidence 0..3) plus a replacement pointer.
  bit      m_vld [N];
  int      m_tag [N];
  int      m_tgt [N];
  int      m_cnt [N];
  int      m_rr;
  longint  m_hits, m_upds, m_misp;

  function automatic int m_find(input int pc);
    for (int i = 0; i < N; i++) if (m_vld[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_vld[i] = 1'b0;
        m_cnt[i] = 2;
      end
      m_rr = 0; m_hits = 0; m_upds = 0; m_misp = 0;
    end else begin
      int  hi, victim, xi;
      bit  acc, alloc;
      hi = m_find(int'(bus.f_pc));
      if (hi >= 0 && m_hits < 64'hFFFF_FFFF) m_hits++;
      xi  = int'(bus.x_idx);
      acc = bus.x_update && m_vld[xi] && m_tag[xi] == int'(bus.x_pc);
      alloc  = bus.d_alloc && m_find(int'(bus.d_pc)) < 0;
      victim = -1;
      for (int i = 0; i < N; i++) if (victim < 0 && !m_vld[i]) victim = i;
      if (alloc && victim < 0) begin
        victim = m_rr;
        m_rr = (m_rr + 1) % N;
      end
      if (alloc && victim == xi) acc = 1'b0;
      if (acc) begin
        if (m_upds < 64'hFFFF_FFFF) m_upds++;
        if ((m_cnt[xi] >= 2) != bus.x_taken && m_misp < 64'hFFFF_FFFF) m_misp++;
        if (bus.x_taken) begin
          m_cnt[xi] = (m_cnt[xi] == 3) ? 3 : m_cnt[xi] + 1;
          m_tgt[xi] = int'(bus.x_target);
        end else begin
          m_cnt[xi] = (m_cnt[xi] == 0) ? 0 : m_cnt[xi] - 1;
        end
      end
      if (alloc) begin
        m_vld[victim] = 1'b1;
        m_tag[victim] = int'(bus.d_pc);
        m_tgt[victim] = int'(bus.d_target);
        m_cnt[victim] = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int hi;
      hi = m_find(int'(bus.f_pc));
      chk("model_hit", 64'(bus.f_hit), 64'(hi >= 0));
      chk("model_idx", 64'(bus.f_hit_idx), (hi >= 0) ? 64'(hi) : 64'd0);
      chk("model_addr", 64'(bus.f_predict_addr), (hi >= 0) ? 64'(unsigned'(m_tgt[hi])) : 64'd0);
      chk("model_pv", 64'(bus.f_predict_valid), 64'(hi >= 0 && m_cnt[hi] >= 2));
`ifdef BTB_PERF_CNT_EN
      chk("model_perf_hits", 64'(perf_hits), 64'(m_hits));
      chk("model_perf_upd", 64'(perf_updates), 64'(m_upds));
      chk("model_perf_misp", 64'(perf_mispred), 64'(m_misp));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt);
    bus.d_alloc = 1'b1; bus.d_pc = pc; bus.d_target = tgt;
    cyc();
    bus.d_alloc = 1'b0;
  endtask

  task automatic upd(input int idx, input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    bus.x_update = 1'b1; bus.x_idx = IDX_W'(idx); bus.x_pc = pc;
    bus.x_taken = tk; bus.x_target = tgt;
    cyc();
    bus.x_update = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit hit, input int idx,
                      input logic [31:0] addr, input bit pv);
    bus.f_pc = pc;
    @(negedge clk);
    chk({name, "_hit"}, 64'(bus.f_hit), 64'(hit));
    chk({name, "_idx"}, 64'(bus.f_hit_idx), 64'(idx));
    chk({name, "_addr"}, 64'(bus.f_predict_addr), 64'(addr));
    chk({name, "_pv"}, 64'(bus.f_predict_valid), 64'(pv));
    cyc();
    bus.f_pc = '0;
  endtask

  initial begin
    bus.f_pc = 32'h100; bus.d_alloc = 0; bus.d_pc = '0; bus.d_target = '0;
    bus.x_update = 0; bus.x_idx = '0; bus.x_pc = '0; bus.x_taken = 0; bus.x_target = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    look("reset", 32'h100, 0, 0, 32'h0, 0);

    alloc(32'h100, 32'h200);
    look("alloc0", 32'h100, 1, 0, 32'h200, 1);

    // Counter floor, climb, ceiling and descent on entry 0.
    repeat (3) upd(0, 32'h100, 0, 32'h0);
    look("cnt_floor", 32'h100, 1, 0, 32'h200, 0);
    upd(0, 32'h100, 1, 32'h300);
    look("cnt_01", 32'h100, 1, 0, 32'h300, 0);
    repeat (3) upd(0, 32'h100, 1, 32'h300);
    look("cnt_sat", 32'h100, 1, 0, 32'h300, 1);
    upd(0, 32'h100, 0, 32'h0);
    look("cnt_10", 32'h100, 1, 0, 32'h300, 1);
    upd(0, 32'h100, 0, 32'h0);
    look("cnt_01b", 32'h100, 1, 0, 32'h300, 0);

    // Fill, round-robin replacement, duplicate suppression.
    for (int i = 1; i < 8; i++) alloc(32'h100 + 32'(i) * 32'h10, 32'h1000 + 32'(i));
    alloc(32'h180, 32'h2180);
    look("evict_old", 32'h100, 0, 0, 32'h0, 0);
    look("evict_new", 32'h180, 1, 0, 32'h2180, 1);
    alloc(32'h110, 32'hDEAD);
    look("dup_keep", 32'h110, 1, 1, 32'h1001, 1);
    alloc(32'h190, 32'h2190);
    look("rr_victim1", 32'h190, 1, 1, 32'h2190, 1);
    look("rr_gone", 32'h110, 0, 0, 32'h0, 0);

    // Stale tag updates are dropped.
    upd(2, 32'h999, 1, 32'hAAA);
    upd(2, 32'h999, 0, 32'h0);
    look("stale", 32'h120, 1, 2, 32'h1002, 1);

    // Allocation beats a same-index update; different indices both land.
    repeat (2) upd(2, 32'h120, 0, 32'h0);
    look("e2_low", 32'h120, 1, 2, 32'h1002, 0);
    bus.x_update = 1; bus.x_idx = 3'd2; bus.x_pc = 32'h120; bus.x_taken = 0;
    alloc(32'h1A0, 32'h21A0);
    bus.x_update = 0;
    look("collide_new", 32'h1A0, 1, 2, 32'h21A0, 1);
    look("collide_old", 32'h120, 0, 0, 32'h0, 0);
    bus.x_update = 1; bus.x_idx = 3'd1; bus.x_pc = 32'h190; bus.x_taken = 1; bus.x_target = 32'h555;
    alloc(32'h1B0, 32'h21B0);
    bus.x_update = 0;
    look("both_alloc", 32'h1B0, 1, 3, 32'h21B0, 1);
    look("both_upd", 32'h190, 1, 1, 32'h555, 1);

    // Mid-run reset clears all entries.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    look("rst_mid", 32'h1B0, 0, 0, 32'h0, 0);

`ifdef BTB_PERF_CNT_EN
    chk("perf_rst_hits", 64'(perf_hits), 64'd0);
    alloc(32'h100, 32'h200);
    bus.f_pc = 32'h100;
    repeat (3) cyc();
    bus.f_pc = 32'h0;
    upd(0, 32'h100, 1, 32'h200);
    upd(0, 32'h100, 0, 32'h0);
    @(negedge clk);
    chk("perf_hits", 64'(perf_hits), 64'd3);
    chk("perf_updates", 64'(perf_updates), 64'd2);
    chk("perf_mispred", 64'(perf_mispred), 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("perf_rst_h", 64'(perf_hits), 64'd0);
    chk("perf_rst_u", 64'(perf_updates), 64'd0);
    chk("perf_rst_m", 64'(perf_mispred), 64'd0);
    cyc();
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
